// File: rtl/mult_sequencer_if.sv
// mult_sequencer_if: button inputs, multiplier LSB and datapath strobes
// exchanged between the multiply control sequencer and the board/datapath.
interface mult_sequencer_if;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_Ld;
  logic ClrAX;
  logic Add;
  logic Sub;
  logic Shift;
  logic Busy;
  logic Done;

  // Board/datapath side: drives buttons and M, observes strobes.
  modport master (
    output Run, ClearA_LoadB, M,
    input  Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done
  );

  // Sequencer side.
  modport slave (
    input  Run, ClearA_LoadB, M,
    output Clr_Ld, ClrAX, Add, Sub, Shift, Busy, Done
  );
endinterface

// File: rtl/mult_sequencer.sv
// mult_sequencer: control FSM for the 8-bit signed shift-add multiplier.
// Sequence: CLEAR, then 8 ADD/SHIFT pairs (Sub instead of Add on the last
// iteration), then DONE until Run is released.
// Optional macro MULT_SEQ_SYNC_EN: two-flop synchronizers on Run and
// ClearA_LoadB (adds 2 cycles to every button-to-state latency).
module mult_sequencer (
  input  logic            Clk,
  input  logic            Reset,
  mult_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             run_n, load_n;

`ifdef MULT_SEQ_SYNC_EN
  logic [1:0] run_sync;
  logic [1:0] load_sync;

  // Two-flop synchronizers; reset to the released (high) level.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      run_sync  <= 2'b11;
      load_sync <= 2'b11;
    end else begin
      run_sync  <= {run_sync[0], bus.Run};
      load_sync <= {load_sync[0], bus.ClearA_LoadB};
    end
  end

  assign run_n  = run_sync[1];
  assign load_n = load_sync[1];
`else
  assign run_n  = bus.Run;
  assign load_n = bus.ClearA_LoadB;
`endif

  // State and iteration counter registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic and Moore strobe decode (M only matters in ADD).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bus.Clr_Ld = 1'b0;
    bus.ClrAX  = 1'b0;
    bus.Add    = 1'b0;
    bus.Sub    = 1'b0;
    bus.Shift  = 1'b0;
    bus.Busy   = 1'b0;
    bus.Done   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!run_n) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (!load_n) begin
          bus.Clr_Ld = 1'b1;
        end
      end
      CLEAR: begin
        bus.ClrAX  = 1'b1;
        bus.Busy   = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        bus.Busy   = 1'b1;
        bus.Add    = bus.M && (cnt != CNT_LAST);
        bus.Sub    = bus.M && (cnt == CNT_LAST);
        state_next = SHIFT;
      end
      SHIFT: begin
        bus.Shift  = 1'b1;
        bus.Busy   = 1'b1;
        cnt_next   = cnt + CNT_W'(1);
        state_next = (cnt == CNT_LAST) ? DONE : ADD;
      end
      DONE: begin
        bus.Done = 1'b1;
        if (run_n) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: directed tests of the multiply control sequencer with a
// small B-register model supplying M.
module tb_mult_sequencer;

`ifdef MULT_SEQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  logic [7:0] sw = 8'h00;
  logic [7:0] tb_b = 8'h00;
  logic [6:0] outs;
  int n_pass = 0;
  int n_total = 0;

  mult_sequencer_if bus ();

  mult_sequencer dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  // B register model: loads from switches, logical right shift on Shift.
  always @(posedge Clk) begin
    if (bus.Clr_Ld) tb_b <= sw;
    else if (bus.Shift) tb_b <= {1'b0, tb_b[7:1]};
  end

  assign bus.M = tb_b[0];
  assign outs = {bus.Clr_Ld, bus.ClrAX, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};

  task automatic test_reset();
    Reset = 1'b0;
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      n_total++;
      if (outs !== 7'b0) $display("FAIL reset_hold cyc%0d: got %b expected %b", i, outs, 7'b0);
      else n_pass++;
    end
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    bus.Run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      n_total++;
      if (outs !== 7'b0) $display("FAIL reset_idle cyc%0d: got %b expected %b", i, outs, 7'b0);
      else n_pass++;
    end
  endtask

  task automatic test_load(input logic [7:0] val);
    logic [6:0] exp;
    sw = val;
    for (int i = 0; i < 3 + L + 2; i++) begin
      @(posedge Clk);
      #1;
      bus.ClearA_LoadB = (i < 3) ? 1'b0 : 1'b1;
      @(negedge Clk);
      exp = {(i >= L && i < 3 + L), 6'b0};
      n_total++;
      if (outs !== exp) $display("FAIL load cyc%0d: got %b expected %b", i, outs, exp);
      else n_pass++;
    end
    n_total++;
    if (tb_b !== val) $display("FAIL load_b: got %h expected %h", tb_b, val);
    else n_pass++;
  endtask

  // Run pulse sampled at edge 0; checks every output for cycles 1..20+L.
  // Assumes B = 0x81 was loaded beforehand.
  task automatic test_multiply();
    logic [6:0] exp;
    int cp;
    @(posedge Clk);
    #1;
    bus.Run = 1'b0;
    @(posedge Clk);
    #1;
    bus.Run = 1'b1;
    for (int c = 1; c <= 20 + L; c++) begin
      @(negedge Clk);
      cp = c - L;
      exp[6] = 1'b0;
      exp[5] = (cp == 1);
      exp[4] = (cp == 2);
      exp[3] = (cp == 16);
      exp[2] = (cp >= 3 && cp <= 17 && (cp % 2) == 1);
      exp[1] = (cp >= 1 && cp <= 17);
      exp[0] = (cp >= 18 && cp <= 18 + L);
      n_total++;
      if (outs !== exp) $display("FAIL multiply cyc%0d: got %b expected %b", c, outs, exp);
      else n_pass++;
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic test_held_run();
    int n_clr, n_shift, n_done;
    n_clr = 0;
    n_shift = 0;
    n_done = 0;
    @(posedge Clk);
    #1;
    bus.Run = 1'b0;
    @(posedge Clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (bus.ClrAX) n_clr++;
      if (bus.Shift) n_shift++;
      if (bus.Done) n_done++;
    end
    n_total++;
    if (n_clr !== 1) $display("FAIL held_clrax_count: got %0d expected 1", n_clr);
    else n_pass++;
    n_total++;
    if (n_shift !== 8) $display("FAIL held_shift_count: got %0d expected 8", n_shift);
    else n_pass++;
    n_total++;
    if (n_done !== 23 - L) $display("FAIL held_done_count: got %0d expected %0d", n_done, 23 - L);
    else n_pass++;
    @(posedge Clk);
    #1;
    bus.Run = 1'b1;
    for (int c = 41; c <= 44; c++) begin
      @(negedge Clk);
      n_total++;
      if (bus.Done !== (c < 42 + L)) $display("FAIL held_release cyc%0d: got Done=%b expected %b", c, bus.Done, (c < 42 + L));
      else n_pass++;
      n_total++;
      if (bus.Busy !== 1'b0) $display("FAIL held_release_busy cyc%0d: got %b expected 0", c, bus.Busy);
      else n_pass++;
    end
  endtask

  task automatic test_mid_op_reset();
    @(posedge Clk);
    #1;
    bus.Run = 1'b0;
    @(posedge Clk);
    #1;
    bus.Run = 1'b1;
    for (int c = 1; c <= 8 + L; c++) @(negedge Clk);
    n_total++;
    if ({bus.Busy, bus.Shift, bus.ClrAX} !== 3'b100) $display("FAIL midop_in_add: got busy/shift/clrax %b expected 100", {bus.Busy, bus.Shift, bus.ClrAX});
    else n_pass++;
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      n_total++;
      if (outs !== 7'b0) $display("FAIL midop_after_reset cyc%0d: got %b expected %b", i, outs, 7'b0);
      else n_pass++;
    end
    test_load(8'h81);
    test_multiply();
  endtask

  task automatic test_priority();
    bool_done_wait: begin end
    @(posedge Clk);
    #1;
    bus.Run = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    n_total++;
    if (bus.Clr_Ld !== 1'b0) $display("FAIL prio_same_cycle: got Clr_Ld=%b expected 0", bus.Clr_Ld);
    else n_pass++;
    @(posedge Clk);
    #1;
    bus.Run = 1'b1;
    bus.ClearA_LoadB = 1'b1;
    for (int c = 1; c <= 3 + L; c++) begin
      @(negedge Clk);
      n_total++;
      if ({bus.Clr_Ld, bus.ClrAX} !== {1'b0, (c == 1 + L)})
        $display("FAIL prio cyc%0d: got clr_ld/clrax %b%b expected 0%b", c, bus.Clr_Ld, bus.ClrAX, (c == 1 + L));
      else n_pass++;
    end
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge Clk);
        if (bus.Clr_Ld) begin
          n_total++;
          $display("FAIL prio_late_clr_ld: got 1 expected 0");
        end
        if (bus.Done) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b1) $display("FAIL prio_done_timeout: got Done never expected 1");
      else n_pass++;
    end
    repeat (3) @(posedge Clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_load(8'h81);
    test_multiply();
    test_load(8'h81);
    test_held_run();
    test_mid_op_reset();
    test_priority();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
